sum_entry_ctrl: RTL

Keypad-entry controller that sequences the two-operand 3-digit adder datapath.
- Debounces the raw 4-bit keypad code and turns each press into exactly one key event.
- Runs the entry state machine: operand A digits, '+', operand B digits, '=', compute, show.
- Drives per-digit load strobes, clear and compute strobes, and display select to the adder and display mux.

---
 rtl/sum_entry_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sum_entry_ctrl.sv
// Keypad entry controller for the two-operand adder: debounces keys, sequences
// digit loads, clear and compute. Optional SUM_AUTO_EQ_EN starts the sum on the last B digit.
module sum_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sample,
  output logic       ld_en,
  output logic       ld_opnd,
  output logic [1:0] ld_pos,
  output logic [3:0] ld_digit,
  output logic       clr_en,
  output logic       sum_go,
  output logic [1:0] disp_sel,
  output logic       err,
  output logic [1:0] state_dbg
);

  localparam logic [7:0] DB    = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] DB_M1 = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] DIG   = 3'(DIGITS);

  localparam logic [3:0] K_PLUS = 4'hA;
  localparam logic [3:0] K_EQ   = 4'hB;
  localparam logic [3:0] K_CLR  = 4'hC;
  localparam logic [3:0] K_BS   = 4'hD;
  localparam logic [3:0] K_NONE = 4'hF;

  typedef enum logic [1:0] {
    ENT_A = 2'd0,
    ENT_B = 2'd1,
    CALC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  // Debounce: hit pulses once per stable run of DEBOUNCE_CYCLES samples;
  // armed records that a release (0xF) was accepted since the last event.
  logic [3:0] s_q, s_prev, hit_code;
  logic [7:0] stab;
  logic       hit, armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= K_NONE;
      s_prev   <= K_NONE;
      hit_code <= K_NONE;
      stab     <= 8'd0;
      hit      <= 1'b0;
      armed    <= 1'b0;
    end else begin
      s_q      <= sample;
      s_prev   <= s_q;
      hit_code <= s_q;
      if (s_q != s_prev) begin
        stab <= 8'd1;
        hit  <= (DB == 8'd1);
      end else begin
        if (stab != DB) stab <= stab + 8'd1;
        hit <= (stab == DB_M1);
      end
      if (hit) armed <= (hit_code == K_NONE);
    end
  end

  logic       key_ev;
  logic [3:0] key;
  logic       is_digit;

  assign key      = hit_code;
  assign key_ev   = hit && armed && (hit_code != K_NONE);
  assign is_digit = (key <= 4'd9);

  // Entry FSM: state, digit count and every output are registered together.
  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       ld_en_n, ld_opnd_n, clr_n, go_n, err_n;
  logic [1:0] ld_pos_n, disp_n;
  logic [3:0] ld_digit_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ENT_A;
      cnt      <= 3'd0;
      ld_en    <= 1'b0;
      ld_opnd  <= 1'b0;
      ld_pos   <= 2'd0;
      ld_digit <= 4'd0;
      clr_en   <= 1'b0;
      sum_go   <= 1'b0;
      disp_sel <= 2'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ld_en    <= ld_en_n;
      ld_opnd  <= ld_opnd_n;
      ld_pos   <= ld_pos_n;
      ld_digit <= ld_digit_n;
      clr_en   <= clr_n;
      sum_go   <= go_n;
      disp_sel <= disp_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ld_en_n    = 1'b0;
    ld_opnd_n  = ld_opnd;
    ld_pos_n   = ld_pos;
    ld_digit_n = ld_digit;
    clr_n      = 1'b0;
    err_n      = 1'b0;
    case (state)
      ENT_A, ENT_B: begin
        if (key_ev) begin
          if (is_digit) begin
            if (cnt < DIG) begin
              ld_en_n    = 1'b1;
              ld_opnd_n  = (state == ENT_B);
              ld_pos_n   = cnt[1:0];
              ld_digit_n = key;
              cnt_n      = cnt + 3'd1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            case (key)
              K_PLUS: begin
                if (state == ENT_A && cnt == DIG) begin
                  state_n = ENT_B;
                  cnt_n   = 3'd0;
                end else begin
                  err_n = 1'b1;
                end
              end
              K_EQ: begin
                if (state == ENT_B && cnt == DIG) state_n = CALC;
                else err_n = 1'b1;
              end
              K_CLR: begin
                clr_n   = 1'b1;
                state_n = ENT_A;
                cnt_n   = 3'd0;
              end
              K_BS: begin
                if (cnt != 3'd0) begin
                  ld_en_n    = 1'b1;
                  ld_opnd_n  = (state == ENT_B);
                  ld_pos_n   = 2'(cnt - 3'd1);
                  ld_digit_n = 4'd0;
                  cnt_n      = cnt - 3'd1;
                end else begin
                  err_n = 1'b1;
                end
              end
              default: err_n = 1'b1;
            endcase
          end
        end
`ifdef SUM_AUTO_EQ_EN
        else if (state == ENT_B && cnt == DIG) begin
          state_n = CALC;
        end
`endif
      end
      CALC: state_n = SHOW;
      SHOW: begin
        if (key_ev) begin
          if (is_digit || key == K_CLR) begin
            clr_n   = 1'b1;
            state_n = ENT_A;
            cnt_n   = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = ENT_A;
    endcase
    // CALC always lasts one cycle, so sum_go is a single-cycle strobe.
    go_n   = (state_n == CALC);
    disp_n = (state_n == ENT_A) ? 2'd0 : (state_n == ENT_B) ? 2'd1 : 2'd2;
  end

  assign state_dbg = state;

endmodule
